uart_rx: RTL and testbench

- 8E1 UART receiver: start bit, 8 data bits LSB-first, one even-parity bit, one stop bit. Parity bit equals the XOR of the 8 data bits.
- Pairs with the existing Tx block on the same Clock_2br domain and bit period. It is the receive half of the full-duplex link.
- Takes the asynchronous serial line Rx and presents the received byte with a one-cycle Ready strobe plus error flags.

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8E1 UART receiver: 2-flop synchronised line, mid-bit sampling, one-cycle
// Ready strobe with parity and framing error flags held until the next frame.
module uart_rx #(
  parameter int BIT_TICKS  = 5209,
  parameter int HALF_TICKS = 2604
) (
  input  logic       Clock_2br,
  input  logic       Reset,
  input  logic       Rx,
  output logic [7:0] Data,
  output logic       Ready,
  output logic       Parity_Err,
  output logic       Frame_Err,
  output logic       Busy
);

  typedef enum logic [3:0] {
    ST_ESPERA  = 4'd0,
    ST_INICIO  = 4'd1,
    ST_B0      = 4'd2,
    ST_B1      = 4'd3,
    ST_B2      = 4'd4,
    ST_B3      = 4'd5,
    ST_B4      = 4'd6,
    ST_B5      = 4'd7,
    ST_B6      = 4'd8,
    ST_B7      = 4'd9,
    ST_PARIDAD = 4'd10,
    ST_STOP    = 4'd11
  } state_t;

  localparam logic [12:0] C_BIT_LAST  = 13'(BIT_TICKS - 1);
  localparam logic [12:0] C_HALF_LAST = 13'(HALF_TICKS - 1);

  logic        r_sync1;
  logic        r_rx_s;
  logic        r_rx_prev;
  state_t      r_state;
  logic [12:0] r_cnt;
  logic [7:0]  r_shift;
  logic        r_parity;

  logic        w_fall;
  logic        w_bit_end;
  logic        w_half_end;
  logic [2:0]  w_bit_idx;
  state_t      w_next_bit_state;

  // Only a true high-to-low transition starts a frame; a stuck-low line never does.
  assign w_fall           = r_rx_prev & ~r_rx_s;
  assign w_bit_end        = (r_cnt == C_BIT_LAST);
  assign w_half_end       = (r_cnt == C_HALF_LAST);
  assign w_bit_idx        = 3'(r_state - ST_B0);
  assign w_next_bit_state = state_t'(r_state + 4'd1);

  always_ff @(posedge Clock_2br or posedge Reset) begin
    if (Reset) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= Rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge Clock_2br or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_ESPERA;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      Data       <= '0;
      Ready      <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err  <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Ready <= 1'b0;
      case (r_state)
        ST_ESPERA: begin
          r_cnt <= '0;
          if (w_fall) begin
            r_state <= ST_INICIO;
            Busy    <= 1'b1;
          end else begin
            Busy    <= 1'b0;
          end
        end
        ST_INICIO: begin
          if (w_half_end) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= ST_ESPERA;
              Busy    <= 1'b0;
            end else begin
              r_state <= ST_B0;
            end
          end else begin
            r_cnt <= r_cnt + 13'd1;
          end
        end
        ST_B0, ST_B1, ST_B2, ST_B3, ST_B4, ST_B5, ST_B6, ST_B7: begin
          if (w_bit_end) begin
            r_shift[w_bit_idx] <= r_rx_s;
            r_cnt              <= '0;
            r_state            <= w_next_bit_state;
          end else begin
            r_cnt <= r_cnt + 13'd1;
          end
        end
        ST_PARIDAD: begin
          if (w_bit_end) begin
            r_parity <= r_rx_s;
            r_cnt    <= '0;
            r_state  <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 13'd1;
          end
        end
        ST_STOP: begin
          // Deliver at mid-stop so the second half-bit is spent in Espera.
          if (w_bit_end) begin
            Data       <= r_shift;
            Parity_Err <= r_parity ^ (^r_shift);
            Frame_Err  <= ~r_rx_s;
            Ready      <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_ESPERA;
            Busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 13'd1;
          end
        end
        default: begin
          r_state <= ST_ESPERA;
          r_cnt   <= '0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with short bit times; a negedge monitor logs every
// Ready strobe and the frames are compared against hand-computed expectations.
module tb_uart_rx;

  localparam int BT = 16;
  localparam int HT = 8;
  localparam int LAT = HT + 10 * BT;

  logic       Clock_2br;
  logic       Reset;
  logic       Rx;
  logic [7:0] Data;
  logic       Ready;
  logic       Parity_Err;
  logic       Frame_Err;
  logic       Busy;

  uart_rx #(.BIT_TICKS(BT), .HALF_TICKS(HT)) dut (
    .Clock_2br (Clock_2br),
    .Reset     (Reset),
    .Rx        (Rx),
    .Data      (Data),
    .Ready     (Ready),
    .Parity_Err(Parity_Err),
    .Frame_Err (Frame_Err),
    .Busy      (Busy)
  );

  // clock / reset
  initial Clock_2br = 1'b0;
  always #5 Clock_2br = ~Clock_2br;

  int n_total = 0;
  int n_bad   = 0;

  // scoreboard: {frame_err, parity_err, data}
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int         lat_q[$];
  int         cyc_q[$];
  logic       busy_after_q[$];

  int   cyc = 0;
  int   last_rise = 0;
  int   n_busy_rise = 0;
  int   n_wide = 0;
  logic busy_d = 1'b0;
  logic ready_d = 1'b0;

  always @(posedge Clock_2br) cyc <= cyc + 1;

  always @(negedge Clock_2br) begin
    if (Busy && !busy_d) begin
      last_rise   <= cyc;
      n_busy_rise <= n_busy_rise + 1;
    end
    if (Ready) begin
      got_q.push_back({Frame_Err, Parity_Err, Data});
      lat_q.push_back(cyc - last_rise);
      cyc_q.push_back(cyc);
    end
    if (ready_d) busy_after_q.push_back(Busy);
    if (Ready && ready_d) n_wide <= n_wide + 1;
    busy_d  <= Busy;
    ready_d <= Ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge Clock_2br);
  endtask

  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (BT) @(negedge Clock_2br);
  endtask

  // Line is left at the stop-bit level; callers restore idle as needed.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic check_frames();
    logic [9:0] e;
    logic [9:0] g;
    check("frame_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check("frame_data", {24'd0, g[7:0]}, {24'd0, e[7:0]});
      check("parity_err", {31'd0, g[8]}, {31'd0, e[8]});
      check("frame_err", {31'd0, g[9]}, {31'd0, e[9]});
      check("ready_latency", lat_q.pop_front(), LAT);
      if (busy_after_q.size() > 0)
        check("busy_after_ready", {31'd0, busy_after_q.pop_front()}, 32'd0);
    end
    exp_q.delete();
    got_q.delete();
    lat_q.delete();
    cyc_q.delete();
    busy_after_q.delete();
  endtask

  int rise_before;
  int gap;

  initial begin
    Reset = 1'b1;
    Rx    = 1'b1;
    repeat (3) @(negedge Clock_2br);
    check("rst_data", {24'd0, Data}, 32'd0);
    check("rst_ready", {31'd0, Ready}, 32'd0);
    check("rst_perr", {31'd0, Parity_Err}, 32'd0);
    check("rst_ferr", {31'd0, Frame_Err}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;
    idle(BT);

    // good frame 0xA5: four ones, parity 0
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(2 * BT);
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    check_frames();

    // parity cases
    send_frame(8'h01, 1'b0, 1'b1); exp_q.push_back({1'b0, 1'b1, 8'h01});
    idle(2 * BT);
    send_frame(8'h3C, 1'b0, 1'b1); exp_q.push_back({1'b0, 1'b0, 8'h3C});
    idle(2 * BT);
    send_frame(8'h07, 1'b1, 1'b1); exp_q.push_back({1'b0, 1'b0, 8'h07});
    idle(2 * BT);
    send_frame(8'hA5, 1'b1, 1'b1); exp_q.push_back({1'b0, 1'b1, 8'hA5});
    idle(2 * BT);
    check_frames();

    // framing error, line stuck low afterwards
    send_frame(8'hFF, 1'b0, 1'b0);
    repeat (3 * BT) @(negedge Clock_2br);
    exp_q.push_back({1'b1, 1'b0, 8'hFF});
    check_frames();
    check("busy_stuck_low", {31'd0, Busy}, 32'd0);
    idle(2 * BT);
    check_frames();
    send_frame(8'h12, 1'b0, 1'b1); exp_q.push_back({1'b0, 1'b0, 8'h12});
    idle(2 * BT);
    check_frames();

    // 4-cycle low glitch: false start
    rise_before = n_busy_rise;
    Rx = 1'b0;
    repeat (4) @(negedge Clock_2br);
    idle(3 * BT);
    check("glitch_inicio", n_busy_rise - rise_before, 1);
    check_frames();
    check("glitch_data", {24'd0, Data}, 32'h12);
    check("glitch_perr", {31'd0, Parity_Err}, 32'd0);
    check("glitch_ferr", {31'd0, Frame_Err}, 32'd0);
    check("glitch_busy", {31'd0, Busy}, 32'd0);

    // back-to-back frames
    send_frame(8'h55, 1'b0, 1'b1); exp_q.push_back({1'b0, 1'b0, 8'h55});
    send_frame(8'hAA, 1'b0, 1'b1); exp_q.push_back({1'b0, 1'b0, 8'hAA});
    idle(2 * BT);
    gap = (cyc_q.size() == 2) ? (cyc_q[1] - cyc_q[0]) : -1;
    check("b2b_gap", gap, 11 * BT);
    check_frames();

    // reset during B4 of frame 0x3C
    drive_bit(1'b0);
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
    Rx = 1'b1;
    repeat (HT) @(negedge Clock_2br);
    check("busy_mid_frame", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    #1;
    check("mid_rst_data", {24'd0, Data}, 32'd0);
    check("mid_rst_ready", {31'd0, Ready}, 32'd0);
    check("mid_rst_perr", {31'd0, Parity_Err}, 32'd0);
    check("mid_rst_ferr", {31'd0, Frame_Err}, 32'd0);
    check("mid_rst_busy", {31'd0, Busy}, 32'd0);
    repeat (3) @(negedge Clock_2br);
    Reset = 1'b0;
    idle(12 * BT);
    check_frames();
    check("post_rst_busy", {31'd0, Busy}, 32'd0);
    send_frame(8'hC3, 1'b0, 1'b1); exp_q.push_back({1'b0, 1'b0, 8'hC3});
    idle(2 * BT);
    check_frames();

    check("ready_width", n_wide, 0);

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
